ysyx_23060201_lsu: RTL and testbench
====================================

Name: ysyx_23060201_lsu

Overview:
- Load/store unit; sits directly upstream of the MEM stage.
- Accepts one memory op at a time from EXU via valid/ready.
- Stores: aligns data and generates the byte-lane mask, then drives the MEM write port (wen/waddr/wdata/wmask) for exactly one cycle.
- Loads: issues a read, waits for read-valid with a timeout, sign/zero-extends the result, and hands it to WBU via valid/ready.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- TIMEOUT_CYCLES, 255, max cycles READ waits for mem_rvalid; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EXU presents an op
- in_ready  out  1  LSU can accept an op
- in_is_load  in  1  op is a load
- in_is_store  in  1  op is a store
- in_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_addr  in  ADDR_WIDTH  effective byte address
- in_wdata  in  DATA_WIDTH  store source (rs2)
- mem_wen  out  1  write strobe to MEM
- mem_waddr  out  ADDR_WIDTH  word-aligned write address
- mem_wdata  out  DATA_WIDTH  lane-shifted write data
- mem_wmask  out  8  byte mask; bits[7:4] always 0
- mem_ren  out  1  read request
- mem_raddr  out  ADDR_WIDTH  word-aligned read address
- mem_rdata  in  DATA_WIDTH  read word
- mem_rvalid  in  1  mem_rdata valid this cycle
- out_valid  out  1  result ready for WBU
- out_ready  in  1  WBU accepts
- out_rdata  out  DATA_WIDTH  extended load data (0 for stores)
- out_misalign  out  1  misaligned access, no memory access made
- out_fault  out  1  read timeout

Behaviour:
- States: IDLE, WRITE, READ, RESP.
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0 except in_ready=1.
  - Captured op, data and timeout counter are cleared.
  - An op in flight is dropped with no response.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture funct3, addr and wdata.
  - in_is_store -> WRITE.
  - in_is_load -> READ; if both is_load and is_store are set, load wins.
  - Neither set -> RESP with out_rdata=0.
  - Misaligned op (H/HU with addr[0]=1; W with addr[1:0]!=0) -> RESP with out_misalign=1, out_rdata=0, mem_wen/mem_ren never asserted.
- WRITE:
  - Exactly one cycle: mem_wen=1, mem_waddr={addr[31:2],2'b00}.
  - B: wmask=8'h01<<addr[1:0]; wdata=wdata[7:0]<<(8*addr[1:0]).
  - H: wmask=8'h03<<addr[1:0]; wdata=wdata[15:0]<<(8*addr[1:0]).
  - W: wmask=8'h0F; wdata unchanged.
  - Next state: RESP.
  - mem_wen, mem_wdata and mem_wmask are 0 in every other state; MEM sees no spurious writes.
- READ:
  - mem_ren=1 and mem_raddr=aligned address, held until mem_rvalid.
  - mem_rvalid may arrive in the first READ cycle; then capture mem_rdata and go to RESP.
  - Counter increments each READ cycle without mem_rvalid.
  - When counter==TIMEOUT_CYCLES (TIMEOUT_CYCLES!=0) -> RESP with out_fault=1, out_rdata=0, mem_ren dropped.
  - mem_rvalid on the same cycle the timeout fires: rvalid wins, no fault.
- Load extraction:
  - byte/half selected by addr[1:0] (half uses addr[1]).
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- RESP:
  - out_valid=1; out_rdata/out_misalign/out_fault stable until out_ready.
  - On out_ready -> IDLE; flags clear.
  - in_ready=0, so no new op is accepted in the same cycle out_ready is seen.
- Latency:
  - store: accept -> WRITE(1) -> out_valid in the 2nd cycle after accept.
  - load with immediate rvalid: out_valid in the 2nd cycle after accept.
- Counter is ceil(log2(TIMEOUT_CYCLES+1)) bits and clears on READ entry.

Decomposition:
- Shared defines header holds the funct3 size codes (LSU_B/H/W/BU/HU) and state encodings.
- One sub-module, ysyx_23060201_lsu_align: combinational store lane/mask generation plus load extract/extend, instantiated once for each path.

Test Plan:
- SB addr=0x80000003 wdata=0x12345678 -> one cycle mem_wen=1, waddr=0x80000000, wdata=0x78000000, wmask=0x08; out_valid 2 cycles after accept, rdata=0.
- SW addr=0x80000002 -> out_misalign=1, mem_wen never 1, out_rdata=0.
- LB addr=0x80000001, mem_rdata=0x0000_8000 with rvalid after 3 cycles -> mem_ren held 3 cycles, out_rdata=0xFFFFFF80; LBU same stimulus -> 0x00000080.
- LHU addr=0x80000002, rdata=0xBEEF1234, immediate rvalid -> out_rdata=0x0000BEEF; out_ready held low 4 cycles keeps out_valid and data stable.
- TIMEOUT_CYCLES=4, LW with rvalid never asserted -> out_fault=1 after 4 READ cycles, mem_ren drops; rvalid exactly on cycle 4 -> no fault.
- rst_n low mid-READ -> immediately IDLE, mem_ren=0, out_valid=0, in_ready=1; next op completes normally.

Source files
------------

// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM states
// and the alignment check used at op acceptance.
package ysyx_23060201_lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } lsu_state_e;

    // Size is carried in funct3[1:0]; the sign bit does not affect alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Combinational byte-lane logic: store data/mask placement and load
// extraction with sign/zero extension. Instantiated once per path.
module ysyx_23060201_lsu_align
    import ysyx_23060201_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [31:0] store_word,
    output logic [7:0]  store_mask,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign shamt     = {addr_lo, 3'b000};
    assign load_byte = load_word[shamt +: 8];
    assign load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        store_word = store_data;
        store_mask = 8'h0F;
        case (funct3[1:0])
            2'b00: begin
                store_word = {24'h0, store_data[7:0]} << shamt;
                store_mask = 8'h01 << addr_lo;
            end
            2'b01: begin
                store_word = {16'h0, store_data[15:0]} << shamt;
                store_mask = 8'h03 << addr_lo;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (funct3)
            LSU_B:   load_data = {{24{load_byte[7]}}, load_byte};
            LSU_BU:  load_data = {24'h0, load_byte};
            LSU_H:   load_data = {{16{load_half[15]}}, load_half};
            LSU_HU:  load_data = {16'h0, load_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit between EXU and MEM: one op at a time, single-cycle store
// strobe, load with bounded wait for read-valid, result handed to WBU.
module ysyx_23060201_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [7:0]            mem_wmask,
    output logic                  mem_ren,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rvalid,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic                  out_misalign,
    output logic                  out_fault
);
    import ysyx_23060201_lsu_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_e            state, state_next;
    logic [2:0]            op_funct3;
    logic [ADDR_WIDTH-1:0] op_addr, op_addr_aligned;
    logic [DATA_WIDTH-1:0] op_wdata;
    logic [CNT_W-1:0]      cnt, cnt_inc;
    logic                  in_fire, in_mem_op, in_misalign, timeout_hit;
    logic [31:0]           st_word, ld_data, unused_ld_data, unused_st_word;
    logic [7:0]            st_mask, unused_st_mask;

    assign in_fire         = in_valid && (state == S_IDLE);
    assign in_mem_op       = in_is_load || in_is_store;
    assign in_misalign     = in_mem_op && is_misaligned(in_funct3[1:0], in_addr[1:0]);
    assign op_addr_aligned = {op_addr[ADDR_WIDTH-1:2], 2'b00};
    assign cnt_inc         = cnt + 1'b1;
    // rvalid takes priority over a timeout firing in the same cycle.
    assign timeout_hit     = (TIMEOUT_CYCLES != 0) && !mem_rvalid
                             && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    ysyx_23060201_lsu_align u_store_align (
        .funct3     (op_funct3),
        .addr_lo    (op_addr[1:0]),
        .store_data (op_wdata),
        .load_word  (32'h0),
        .store_word (st_word),
        .store_mask (st_mask),
        .load_data  (unused_ld_data)
    );

    ysyx_23060201_lsu_align u_load_align (
        .funct3     (op_funct3),
        .addr_lo    (op_addr[1:0]),
        .store_data (32'h0),
        .load_word  (mem_rdata),
        .store_word (unused_st_word),
        .store_mask (unused_st_mask),
        .load_data  (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (in_fire) begin
                    if (in_misalign)      state_next = S_RESP;
                    else if (in_is_load)  state_next = S_READ;
                    else if (in_is_store) state_next = S_WRITE;
                    else                  state_next = S_RESP;
                end
            end
            S_WRITE: state_next = S_RESP;
            S_READ:  if (mem_rvalid || timeout_hit) state_next = S_RESP;
            S_RESP:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_funct3    <= '0;
            op_addr      <= '0;
            op_wdata     <= '0;
            cnt          <= '0;
            out_rdata    <= '0;
            out_misalign <= 1'b0;
            out_fault    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        op_funct3    <= in_funct3;
                        op_addr      <= in_addr;
                        op_wdata     <= in_wdata;
                        cnt          <= '0;
                        out_rdata    <= '0;
                        out_misalign <= in_misalign;
                        out_fault    <= 1'b0;
                    end
                end
                S_READ: begin
                    if (mem_rvalid)       out_rdata <= ld_data;
                    else if (timeout_hit) out_fault <= 1'b1;
                    else                  cnt       <= cnt_inc;
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_rdata    <= '0;
                        out_misalign <= 1'b0;
                        out_fault    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_RESP);
    assign mem_wen   = (state == S_WRITE);
    assign mem_waddr = mem_wen ? op_addr_aligned : '0;
    assign mem_wdata = mem_wen ? st_word : '0;
    assign mem_wmask = mem_wen ? st_mask : 8'h00;
    assign mem_ren   = (state == S_READ);
    assign mem_raddr = mem_ren ? op_addr_aligned : '0;

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Self-checking bench for the LSU: directed scenarios plus randomized ops
// compared against a behavioural model of the expected transaction outcome.
module tb_ysyx_23060201_lsu;

    localparam int TMO = 4;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_is_load, in_is_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic        mem_wen, mem_ren, mem_rvalid;
    logic [31:0] mem_waddr, mem_wdata, mem_raddr, mem_rdata;
    logic [7:0]  mem_wmask;
    logic        out_valid, out_ready, out_misalign, out_fault;
    logic [31:0] out_rdata;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int          wen_cnt;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        int          ren_cnt;
        int          lat;
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
        int          bad;
    } obs_t;

    ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_load(in_is_load), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_misalign(out_misalign), .out_fault(out_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Outcome of one op as defined by the LSU contract. delay = READ cycles
    // without rvalid before rvalid is presented.
    function automatic obs_t model(input bit ld, input bit st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd, input int delay);
        obs_t e;
        int off;
        bit mis;
        logic [31:0] b, h;
        e = '{default: 0};
        off = int'(a % 4);
        mis = (ld || st) && (((f3 % 4) == 1 && (off % 2) == 1) || ((f3 % 4) >= 2 && off != 0));
        e.mis = mis;
        if (mis || (!ld && !st)) begin
            e.lat = 1;
        end else if (ld) begin
            if (delay >= TMO) begin
                e.ren_cnt = TMO;
                e.lat     = TMO + 1;
                e.fault   = 1'b1;
            end else begin
                e.ren_cnt = delay + 1;
                e.lat     = delay + 2;
                b = (rd >> (8 * off)) & 32'hFF;
                h = (rd >> (16 * (off / 2))) & 32'hFFFF;
                case (f3)
                    3'b000:  e.rdata = (b >= 128) ? b + 32'hFFFF_FF00 : b;
                    3'b100:  e.rdata = b;
                    3'b001:  e.rdata = (h >= 32768) ? h + 32'hFFFF_0000 : h;
                    3'b101:  e.rdata = h;
                    default: e.rdata = rd;
                endcase
            end
        end else begin
            e.wen_cnt = 1;
            e.lat     = 2;
            e.waddr   = a - off;
            case (f3 % 4)
                0:       begin e.wdata = (wd & 32'hFF)   << (8 * off); e.wmask = 8'(1 << off); end
                1:       begin e.wdata = (wd & 32'hFFFF) << (8 * off); e.wmask = 8'(3 << off); end
                default: begin e.wdata = wd;                          e.wmask = 8'h0F;       end
            endcase
        end
        return e;
    endfunction

    // Drives one op starting in an IDLE cycle (#1 after a posedge) and returns
    // what was observed; protocol violations are accumulated in o.bad.
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int delay, input int hold, output obs_t o);
        bit seen, done;
        int rc;
        o = '{default: 0};
        in_valid = 1'b1; in_is_load = ld; in_is_store = st;
        in_funct3 = f3; in_addr = a; in_wdata = wd; mem_rdata = rd;
        if (in_ready !== 1'b1) o.bad++;
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
        in_addr = $urandom; in_wdata = $urandom;
        seen = 0; done = 0; rc = 0;
        for (int c = 1; c <= 80 && !done; c++) begin
            if (mem_wen === 1'b1) begin
                o.wen_cnt++;
                o.waddr = mem_waddr; o.wdata = mem_wdata; o.wmask = mem_wmask;
            end else if (mem_wdata !== 32'h0 || mem_wmask !== 8'h0) o.bad++;
            if (mem_ren === 1'b1) begin
                o.ren_cnt++;
                if (mem_raddr !== {a[31:2], 2'b00}) o.bad++;
            end
            mem_rvalid = (mem_ren === 1'b1) && (o.ren_cnt == delay + 1);
            if (out_valid === 1'b1) begin
                if (!seen) begin
                    seen = 1; o.lat = c;
                    o.rdata = out_rdata; o.mis = out_misalign; o.fault = out_fault;
                end else if (out_rdata !== o.rdata || out_misalign !== o.mis || out_fault !== o.fault)
                    o.bad++;
                if (in_ready !== 1'b0) o.bad++;
                rc++;
                out_ready = (rc > hold);
            end else if (seen) begin
                out_ready = 1'b0;
                done = 1;
            end
            if (!done) begin
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            o.bad += 100;
            $display("FAIL op_timeout: no response within cycle budget");
        end
        out_ready = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (mem_wen !== 1'b0 || mem_wmask !== 8'h0 || mem_wdata !== 32'h0 || mem_waddr !== 32'h0) begin
            n_err++; $display("FAIL rst_write_port: wen=%b mask=%h data=%h addr=%h want all 0", mem_wen, mem_wmask, mem_wdata, mem_waddr); end
        n_cmp++; if (mem_ren !== 1'b0 || mem_raddr !== 32'h0) begin
            n_err++; $display("FAIL rst_read_port: ren=%b addr=%h want 0", mem_ren, mem_raddr); end
        n_cmp++; if (out_valid !== 1'b0 || out_rdata !== 32'h0 || out_misalign !== 1'b0 || out_fault !== 1'b0) begin
            n_err++; $display("FAIL rst_out: valid=%b rdata=%h mis=%b fault=%b want 0", out_valid, out_rdata, out_misalign, out_fault); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        obs_t o;
        do_op(0, 1, 3'b000, 32'h8000_0003, 32'h1234_5678, 32'h0, 0, 0, o);
        n_cmp++; if (o.wen_cnt !== 1) begin n_err++; $display("FAIL sb_wen_cycles: got %0d want 1", o.wen_cnt); end
        n_cmp++; if (o.waddr !== 32'h8000_0000) begin n_err++; $display("FAIL sb_waddr: got %h want 80000000", o.waddr); end
        n_cmp++; if (o.wdata !== 32'h7800_0000) begin n_err++; $display("FAIL sb_wdata: got %h want 78000000", o.wdata); end
        n_cmp++; if (o.wmask !== 8'h08) begin n_err++; $display("FAIL sb_wmask: got %h want 08", o.wmask); end
        n_cmp++; if (o.lat !== 2 || o.rdata !== 32'h0 || o.bad !== 0) begin
            n_err++; $display("FAIL sb_resp: lat=%0d rdata=%h bad=%0d want 2/0/0", o.lat, o.rdata, o.bad); end
        do_op(0, 1, 3'b001, 32'h8000_0012, 32'hAAAA_BEEF, 32'h0, 0, 0, o);
        n_cmp++; if (o.wdata !== 32'hBEEF_0000 || o.wmask !== 8'h0C || o.waddr !== 32'h8000_0010) begin
            n_err++; $display("FAIL sh_lane: data=%h mask=%h addr=%h want BEEF0000/0C/80000010", o.wdata, o.wmask, o.waddr); end
    endtask

    task automatic test_misalign();
        obs_t o;
        do_op(0, 1, 3'b010, 32'h8000_0002, 32'hDEAD_BEEF, 32'h0, 0, 0, o);
        n_cmp++; if (o.mis !== 1'b1) begin n_err++; $display("FAIL sw_mis_flag: got %b want 1", o.mis); end
        n_cmp++; if (o.wen_cnt !== 0 || o.rdata !== 32'h0 || o.bad !== 0) begin
            n_err++; $display("FAIL sw_mis_side: wen=%0d rdata=%h bad=%0d want 0/0/0", o.wen_cnt, o.rdata, o.bad); end
        do_op(1, 0, 3'b101, 32'h8000_0001, 32'h0, 32'h1111_2222, 0, 0, o);
        n_cmp++; if (o.mis !== 1'b1 || o.ren_cnt !== 0) begin
            n_err++; $display("FAIL lhu_mis: mis=%b ren=%0d want 1/0", o.mis, o.ren_cnt); end
    endtask

    task automatic test_load();
        obs_t o;
        do_op(1, 0, 3'b000, 32'h8000_0001, 32'h0, 32'h0000_8000, 2, 0, o);
        n_cmp++; if (o.ren_cnt !== 3) begin n_err++; $display("FAIL lb_ren_cycles: got %0d want 3", o.ren_cnt); end
        n_cmp++; if (o.rdata !== 32'hFFFF_FF80 || o.bad !== 0) begin
            n_err++; $display("FAIL lb_rdata: got %h bad=%0d want FFFFFF80", o.rdata, o.bad); end
        do_op(1, 0, 3'b100, 32'h8000_0001, 32'h0, 32'h0000_8000, 2, 0, o);
        n_cmp++; if (o.rdata !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_rdata: got %h want 00000080", o.rdata); end
        do_op(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'hBEEF_1234, 0, 4, o);
        n_cmp++; if (o.rdata !== 32'h0000_BEEF || o.lat !== 2) begin
            n_err++; $display("FAIL lhu_rdata: got %h lat=%0d want 0000BEEF lat 2", o.rdata, o.lat); end
        n_cmp++; if (o.bad !== 0) begin n_err++; $display("FAIL lhu_hold_stable: violations=%0d want 0", o.bad); end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_op(1, 0, 3'b010, 32'h8000_0008, 32'h0, 32'h5555_AAAA, 99, 0, o);
        n_cmp++; if (o.fault !== 1'b1 || o.rdata !== 32'h0) begin
            n_err++; $display("FAIL lw_timeout_fault: fault=%b rdata=%h want 1/0", o.fault, o.rdata); end
        n_cmp++; if (o.ren_cnt !== TMO || o.lat !== TMO + 1) begin
            n_err++; $display("FAIL lw_timeout_ren: ren=%0d lat=%0d want %0d/%0d", o.ren_cnt, o.lat, TMO, TMO + 1); end
        do_op(1, 0, 3'b010, 32'h8000_0008, 32'h0, 32'h5555_AAAA, TMO - 1, 0, o);
        n_cmp++; if (o.fault !== 1'b0 || o.rdata !== 32'h5555_AAAA || o.ren_cnt !== TMO) begin
            n_err++; $display("FAIL lw_rvalid_at_limit: fault=%b rdata=%h ren=%0d want 0/5555AAAA/%0d", o.fault, o.rdata, o.ren_cnt, TMO); end
    endtask

    task automatic test_reset_mid_read();
        obs_t o;
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0;
        in_funct3 = 3'b010; in_addr = 32'h8000_0020; mem_rvalid = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; in_is_load = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (mem_ren !== 1'b1) begin n_err++; $display("FAIL mid_read_pre: ren=%b want 1", mem_ren); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_ren !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_read_reset: ren=%b valid=%b ready=%b want 0/0/1", mem_ren, out_valid, in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(1, 0, 3'b010, 32'h8000_0004, 32'h0, 32'hCAFE_BABE, 1, 0, o);
        n_cmp++; if (o.rdata !== 32'hCAFE_BABE || o.lat !== 3 || o.bad !== 0) begin
            n_err++; $display("FAIL after_reset_lw: rdata=%h lat=%0d bad=%0d want CAFEBABE/3/0", o.rdata, o.lat, o.bad); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        do_op(0, 1, 3'b010, 32'h8000_0040, 32'h0BAD_F00D, 32'h0, 0, 0, o);
        n_cmp++; if (o.wdata !== 32'h0BAD_F00D || o.wmask !== 8'h0F || o.lat !== 2) begin
            n_err++; $display("FAIL b2b_sw: data=%h mask=%h lat=%0d want 0BADF00D/0F/2", o.wdata, o.wmask, o.lat); end
        do_op(1, 1, 3'b001, 32'h8000_0042, 32'h0, 32'h8001_0002, 0, 0, o);
        n_cmp++; if (o.wen_cnt !== 0 || o.rdata !== 32'hFFFF_8001 || o.lat !== 2) begin
            n_err++; $display("FAIL b2b_load_wins: wen=%0d rdata=%h lat=%0d want 0/FFFF8001/2", o.wen_cnt, o.rdata, o.lat); end
        do_op(0, 0, 3'b010, 32'h8000_0003, 32'h1, 32'h0, 0, 0, o);
        n_cmp++; if (o.lat !== 1 || o.rdata !== 32'h0 || o.mis !== 1'b0 || o.wen_cnt !== 0) begin
            n_err++; $display("FAIL b2b_nop: lat=%0d rdata=%h mis=%b wen=%0d want 1/0/0/0", o.lat, o.rdata, o.mis, o.wen_cnt); end
    endtask

    task automatic test_random();
        obs_t o, e;
        bit ld, st;
        logic [2:0] f3;
        logic [31:0] a, wd, rd;
        int kind, delay, hold;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 5);
            ld = (kind == 2 || kind == 3 || kind == 5);
            st = (kind == 0 || kind == 1 || kind == 5);
            case ($urandom_range(0, 4))
                0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
            endcase
            if (st && !ld && f3[2]) f3 = {1'b0, f3[1:0]};
            a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            wd = $urandom; rd = $urandom;
            delay = $urandom_range(0, TMO + 1);
            hold = $urandom_range(0, 2);
            e = model(ld, st, f3, a, wd, rd, delay);
            do_op(ld, st, f3, a, wd, rd, delay, hold, o);
            n_cmp++; if (o.wen_cnt !== e.wen_cnt || o.waddr !== e.waddr || o.wdata !== e.wdata || o.wmask !== e.wmask) begin
                n_err++; $display("FAIL rnd%0d_write: wen=%0d a=%h d=%h m=%h want %0d/%h/%h/%h", i,
                                  o.wen_cnt, o.waddr, o.wdata, o.wmask, e.wen_cnt, e.waddr, e.wdata, e.wmask); end
            n_cmp++; if (o.ren_cnt !== e.ren_cnt || o.lat !== e.lat) begin
                n_err++; $display("FAIL rnd%0d_timing: ren=%0d lat=%0d want %0d/%0d", i, o.ren_cnt, o.lat, e.ren_cnt, e.lat); end
            n_cmp++; if (o.rdata !== e.rdata || o.mis !== e.mis || o.fault !== e.fault || o.bad !== 0) begin
                n_err++; $display("FAIL rnd%0d_resp: rdata=%h mis=%b fault=%b bad=%0d want %h/%b/%b/0", i,
                                  o.rdata, o.mis, o.fault, o.bad, e.rdata, e.mis, e.fault); end
        end
    endtask

    initial begin
        in_valid = 0; in_is_load = 0; in_is_store = 0; in_funct3 = 0;
        in_addr = 0; in_wdata = 0; mem_rdata = 0; mem_rvalid = 0; out_ready = 0;
        test_reset();
        test_store();
        test_misalign();
        test_load();
        test_timeout();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
